btb_update_ctrl: RTL

Sequencer and arbiter for a single-ported BTB tag/target array. It flushes the array after reset or on request. It buffers taken-branch updates from writeback in a small queue and shares the single array port between IF-stage lookups and those updates, with a starvation guard. It sits between the IF/WB pipeline stages and the BTB storage. Way selection and LRU stay in the array.

---
 rtl/btb_update_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/btb_update_ctrl.sv
// BTB port sequencer: flushes the tag/target array, queues WB taken-branch
// updates and arbitrates the single array port between IF lookups and updates.
module btb_update_ctrl #(
  parameter  int LINES      = 32,
  parameter  int QDEPTH     = 2,
  parameter  int STARVE_MAX = 4,
  localparam int IW         = $clog2(LINES),
  localparam int TW         = 16 - 1 - IW,
  localparam int CW         = $clog2(QDEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          lookup_req,
  input  logic [15:0]   lookup_pc,
  output logic          lookup_grant,
  input  logic          upd_valid,
  input  logic [15:0]   upd_pc,
  input  logic [15:0]   upd_target,
  output logic          upd_ready,
  input  logic          flush_req,
  output logic          busy,
  output logic          arr_en,
  output logic          arr_we,
  output logic          arr_clear,
  output logic [IW-1:0] arr_index,
  output logic [TW-1:0] arr_tag,
  output logic [15:0]   arr_target,
  output logic [CW-1:0] q_count
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  typedef enum logic {S_FLUSH, S_RUN} state_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] tgt;
  } upd_ent_t;

  state_t          r_state;
  logic [IW-1:0]   r_fidx;
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_starve;
  upd_ent_t        r_q [QDEPTH];

  logic            w_run;
  logic            w_lk_win;
  logic            w_pop;
  logic            w_push;
  logic            w_qne;
  upd_ent_t        w_head;

  assign w_run    = (r_state == S_RUN);
  assign w_qne    = (r_cnt != '0);
  assign w_head   = r_q[r_rptr];
  // Lookups win until the head has been denied STARVE_MAX times in a row.
  assign w_lk_win = w_run && lookup_req && (r_starve < 3'(STARVE_MAX));
  assign w_pop    = w_run && !w_lk_win && w_qne;
  assign w_push   = upd_valid && upd_ready;

  assign upd_ready    = w_run && (r_cnt < CW'(QDEPTH));
  assign busy         = !w_run;
  assign lookup_grant = w_lk_win;
  assign q_count      = r_cnt;

  always_comb begin
    arr_en     = 1'b0;
    arr_we     = 1'b0;
    arr_clear  = 1'b0;
    arr_index  = lookup_pc[IW:1];
    arr_tag    = lookup_pc[15:IW+1];
    arr_target = w_head.tgt;
    if (!w_run) begin
      arr_en    = 1'b1;
      arr_clear = 1'b1;
      arr_index = r_fidx;
    end else if (w_lk_win) begin
      arr_en    = 1'b1;
    end else if (w_qne) begin
      arr_en    = 1'b1;
      arr_we    = 1'b1;
      arr_index = w_head.pc[IW:1];
      arr_tag   = w_head.pc[15:IW+1];
    end
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_FLUSH;
      r_fidx   <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_cnt    <= '0;
      r_starve <= '0;
    end else if (flush_req) begin
      r_state  <= S_FLUSH;
      r_fidx   <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_cnt    <= '0;
      r_starve <= '0;
    end else if (r_state == S_FLUSH) begin
      if (r_fidx == IW'(LINES - 1)) begin
        r_state <= S_RUN;
        r_fidx  <= '0;
      end else begin
        r_fidx  <= r_fidx + IW'(1);
      end
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (!w_qne || w_pop)
        r_starve <= '0;
      else if (w_lk_win)
        r_starve <= r_starve + 3'd1;
    end
  end

  // Entry storage needs no reset; occupancy is tracked by r_cnt.
  for (genvar g = 0; g < QDEPTH; g++) begin : g_q
    always_ff @(posedge clk) begin
      if (w_push && (r_wptr == PW'(g)))
        r_q[g] <= '{pc: upd_pc, tgt: upd_target};
    end
  end

endmodule
